rv32_mod_lsu_queued: RTL and testbench
======================================

// Module: rv32_mod_lsu_queued
// PURPOSE
//  Parametrised load/store unit between the RV32 hart and the external data bus.
//  - Buffers up to DEPTH hart requests in order, then issues them one at a time on the dext_* bus.
//  - Splits misaligned accesses that cross a word boundary into two bus beats and merges the results.
//  - Returns sign/zero-extended load data and a single valid or error pulse per request.
// PARAMETERS
//  DEPTH          4   request queue entries; power of 2, >=2
//  MISALIGNED_EN  1   1: split word-crossing accesses; 0: return error, no bus access
// PORTS
//  clk        in   1   clock
//  reset      in   1   asynchronous, active-high reset
//  req        in   1   hart request; accepted when !stall
//  req_type   in   4   [3]=signed load, [2]=rsvd, [1:0]=size (00 B, 01 H, 10 W, 11 illegal)
//  wr         in   1   1=store, 0=load
//  address    in   32  byte address
//  data_i     in   32  store data, LSB-justified
//  data_o     out  32  load result, extended; 0 for stores and errors
//  valid      out  1   one-cycle pulse, request completed OK
//  error      out  1   one-cycle pulse, request failed
//  stall      out  1   queue full; hart holds req
//  dext_req   out  1   bus request; held until dext_ack/dext_err
//  dext_wr    out  1   bus write
//  dext_ack   in   1   beat done OK; dext_di valid same cycle
//  dext_err   in   1   beat failed; wins over dext_ack
//  dext_be    out  4   byte enables
//  dext_addr  out  32  word-aligned address, [1:0]=0
//  dext_do    out  32  lane-aligned store data
//  dext_di    in   32  load data
// BEHAVIOUR
//  - Reset: all outputs 0, queue empty, FSM IDLE. Reset mid-transaction drops every pending
//    request and produces no response.
//  - Queue:
//    - push = req && !stall.
//    - stall = full, combinational, computed from current occupancy only; no push while full,
//      even if a pop happens in the same cycle.
//    - Push and pop in the same cycle are legal when not full.
//  - Byte count: n = 1/2/4 for size 00/01/10. off = addr[1:0].
//  - A request is misaligned when off+n > 4.
//  - Masks and data:
//    - 8-bit mask m = ((1<<n)-1) << off; beat0 be = m[3:0], beat1 be = m[7:4].
//    - Store: 64-bit window = data_i << (8*off); beat0 do = window[31:0], beat1 do = window[63:32].
//    - Unused lanes of dext_do are 0. Loads drive dext_do = 0.
//  - FSM states: IDLE, BEAT0, BEAT1, RESP.
//    - IDLE -> RESP (error, no bus access) when the queue is non-empty and the head has size 11,
//      or is misaligned with MISALIGNED_EN=0.
//    - IDLE -> BEAT0 when the queue is non-empty otherwise: pop the head; register dext_req=1,
//      dext_addr={addr[31:2],2'b00}, be, do, wr.
//    - BEAT0 on ack: capture dext_di into lo. Go to BEAT1 if misaligned (dext_addr += 4, beat1
//      be/do, dext_req stays 1), else to RESP.
//    - BEAT1 on ack: capture dext_di into hi, go to RESP.
//    - err in BEAT0/BEAT1: go to RESP with error; the second beat is never issued.
//    - RESP: registered one-cycle pulse of valid or error.
//      - Load data: ({hi,lo} >> 8*off) truncated to n bytes, sign-extended if req_type[3], else
//        zero-extended. data_o=0 on stores and errors.
//      - Next state is IDLE, or BEAT0 directly if the queue is non-empty (no bubble).
//  - dext_req drops in the cycle after the final ack/err. ack/err seen while dext_req=0 is ignored.
//  - Latency, empty queue: req accepted at edge N -> dext_req high after edge N+1 ->
//    ack sampled at edge M -> valid high for the cycle after edge M+1.
//    The minimum is 3 edges with a zero-wait bus.
//  - Responses are strictly in request order, exactly one per accepted request.
// STRUCTURE
//  - Package rv32_pkg_lsu:
//    - lsu_size_e
//    - lsu_req_t {wr, signed, size, addr, data}
//    - function lsu_be8(size, off)
//    - function lsu_extend(raw, size, signed)
//  - Sub-module rv32_mod_sync_fifo #(WIDTH, DEPTH): request queue with full/empty and an
//    occupancy counter.
// TESTING
//  1. LW 0x100, ack 2 cycles later with di=0xDEADBEEF -> dext_addr=0x100, be=1111,
//     one valid pulse, data_o=0xDEADBEEF.
//  2. LB signed @0x103 with di=0x80000000 -> be=1000, data_o=0xFFFFFF80.
//     The same access as LBU -> data_o=0x00000080.
//  3. LW @0x102:
//     - beat0 @0x100, be=1100, di=0x22110000
//     - beat1 @0x104, be=0011, di=0x00004433
//     -> data_o=0x44332211, one valid pulse.
//  4. SW 0x11223344 @0x103:
//     - beat0 be=1000, do=0x44000000
//     - beat1 @0x104, be=0111, do=0x00112233
//  5. DEPTH=4 with the bus stalled, 6 back-to-back requests:
//     - 1 is popped to the bus and 4 are queued; stall rises after 5 are accepted.
//     - ack everything -> 5 responses in order; the 6th is accepted once stall drops.
//  6. Error paths:
//     - dext_err on beat0 of a misaligned LW -> one error pulse, no beat1.
//     - MISALIGNED_EN=0 -> error pulse, dext_req never rises.
//     - reset while in BEAT1 -> all outputs 0, no pulse.

Source files
------------

// File: rtl/rv32_pkg_lsu.sv
// Shared types and helpers for the queued RV32 load/store unit: request record,
// access sizes, FSM states, byte-lane mask and load-extension functions.
package rv32_pkg_lsu;

  typedef enum logic [1:0] {
    LSU_B = 2'b00,
    LSU_H = 2'b01,
    LSU_W = 2'b10,
    LSU_X = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_RESP
  } lsu_state_e;

  typedef struct packed {
    logic        wr;
    logic        sgn;
    lsu_size_e   size;
    logic [31:0] addr;
    logic [31:0] data;
  } lsu_req_t;

  // Byte-lane mask over two consecutive words; bits [7:4] belong to the second beat.
  function automatic logic [7:0] lsu_be8(input lsu_size_e size, input logic [1:0] off);
    logic [7:0] m;
    case (size)
      LSU_B:   m = 8'h01;
      LSU_H:   m = 8'h03;
      LSU_W:   m = 8'h0f;
      default: m = 8'h00;
    endcase
    return m << off;
  endfunction

  function automatic logic [31:0] lsu_extend(input logic [31:0] raw, input lsu_size_e size,
                                             input logic sgn);
    logic [31:0] r;
    case (size)
      LSU_B:   r = {{24{sgn & raw[7]}}, raw[7:0]};
      LSU_H:   r = {{16{sgn & raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32_mod_sync_fifo.sv
// Single-clock request queue with occupancy counter; storage is not reset,
// only the pointers and the counter are.
module rv32_mod_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rv32_mod_lsu_queued.sv
// Queued load/store unit: buffers hart requests, issues them in order on the
// word-wide external bus, splitting word-crossing accesses into two beats.
module rv32_mod_lsu_queued
  import rv32_pkg_lsu::*;
#(
  parameter int DEPTH         = 4,
  parameter bit MISALIGNED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  req_type,
  input  logic        wr,
  input  logic [31:0] address,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        valid,
  output logic        error,
  output logic        stall,
  output logic        dext_req,
  output logic        dext_wr,
  input  logic        dext_ack,
  input  logic        dext_err,
  output logic [3:0]  dext_be,
  output logic [31:0] dext_addr,
  output logic [31:0] dext_do,
  input  logic [31:0] dext_di
);

  lsu_req_t    push_req, head;
  logic        fifo_full, fifo_empty, push, pop, unused_rsvd;
  lsu_state_e  state_q, state_d;
  logic        dext_req_q, dext_req_d, dext_wr_q, dext_wr_d;
  logic [3:0]  dext_be_q, dext_be_d, be_hi_q, be_hi_d;
  logic [31:0] dext_addr_q, dext_addr_d, dext_do_q, dext_do_d, do_hi_q, do_hi_d;
  logic        cur_wr_q, cur_wr_d, cur_sgn_q, cur_sgn_d, mis_q, mis_d, err_q, err_d;
  lsu_size_e   cur_size_q, cur_size_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] lo_q, lo_d, hi_q, hi_d;
  logic        valid_q, valid_d, error_q, error_d;
  logic [31:0] data_o_q, data_o_d, head_dmask, resp_raw;
  logic [7:0]  head_be8;
  logic [63:0] head_win;
  logic        head_mis, head_bad;

  assign unused_rsvd = req_type[2];
  assign push_req    = '{wr: wr, sgn: req_type[3], size: lsu_size_e'(req_type[1:0]),
                         addr: address, data: data_i};
  assign push        = req && !fifo_full;
  assign stall       = fifo_full;

  rv32_mod_sync_fifo #(.WIDTH($bits(lsu_req_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .wdata_i (push_req),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    case (head.size)
      LSU_B:   head_dmask = 32'h0000_00ff;
      LSU_H:   head_dmask = 32'h0000_ffff;
      default: head_dmask = 32'hffff_ffff;
    endcase
  end

  assign head_be8 = lsu_be8(head.size, head.addr[1:0]);
  assign head_win = {32'h0, head.data & head_dmask} << {head.addr[1:0], 3'b000};
  assign head_mis = |head_be8[7:4];
  assign head_bad = (head.size == LSU_X) || (head_mis && !MISALIGNED_EN);
  assign resp_raw = 32'({hi_q, lo_q} >> {off_q, 3'b000});

  // RESP dispatches the next head exactly like IDLE, so back-to-back requests have no bubble.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    dext_req_d  = dext_req_q;
    dext_wr_d   = dext_wr_q;
    dext_be_d   = dext_be_q;
    dext_addr_d = dext_addr_q;
    dext_do_d   = dext_do_q;
    be_hi_d     = be_hi_q;
    do_hi_d     = do_hi_q;
    cur_wr_d    = cur_wr_q;
    cur_sgn_d   = cur_sgn_q;
    cur_size_d  = cur_size_q;
    off_d       = off_q;
    mis_d       = mis_q;
    err_d       = err_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (!fifo_empty) begin
          pop        = 1'b1;
          cur_wr_d   = head.wr;
          cur_sgn_d  = head.sgn;
          cur_size_d = head.size;
          off_d      = head.addr[1:0];
          mis_d      = head_mis;
          if (head_bad) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else begin
            state_d     = ST_BEAT0;
            err_d       = 1'b0;
            dext_req_d  = 1'b1;
            dext_wr_d   = head.wr;
            dext_addr_d = {head.addr[31:2], 2'b00};
            dext_be_d   = head_be8[3:0];
            be_hi_d     = head_be8[7:4];
            dext_do_d   = head.wr ? head_win[31:0] : '0;
            do_hi_d     = head.wr ? head_win[63:32] : '0;
            hi_d        = '0;
          end
        end
      end
      ST_BEAT0: begin
        if (dext_err) begin
          state_d    = ST_RESP;
          err_d      = 1'b1;
          dext_req_d = 1'b0;
        end else if (dext_ack) begin
          lo_d = dext_di;
          if (mis_q) begin
            state_d     = ST_BEAT1;
            dext_addr_d = dext_addr_q + 32'd4;
            dext_be_d   = be_hi_q;
            dext_do_d   = do_hi_q;
          end else begin
            state_d    = ST_RESP;
            dext_req_d = 1'b0;
          end
        end
      end
      ST_BEAT1: begin
        if (dext_err) begin
          state_d    = ST_RESP;
          err_d      = 1'b1;
          dext_req_d = 1'b0;
        end else if (dext_ack) begin
          hi_d       = dext_di;
          state_d    = ST_RESP;
          dext_req_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d  = (state_q == ST_RESP) && !err_q;
    error_d  = (state_q == ST_RESP) && err_q;
    data_o_d = (valid_d && !cur_wr_q) ? lsu_extend(resp_raw, cur_size_q, cur_sgn_q) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dext_req_q  <= 1'b0;
      dext_wr_q   <= 1'b0;
      dext_be_q   <= '0;
      dext_addr_q <= '0;
      dext_do_q   <= '0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      data_o_q    <= '0;
    end else begin
      state_q     <= state_d;
      dext_req_q  <= dext_req_d;
      dext_wr_q   <= dext_wr_d;
      dext_be_q   <= dext_be_d;
      dext_addr_q <= dext_addr_d;
      dext_do_q   <= dext_do_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      data_o_q    <= data_o_d;
    end
  end

  always_ff @(posedge clk) begin
    be_hi_q    <= be_hi_d;
    do_hi_q    <= do_hi_d;
    cur_wr_q   <= cur_wr_d;
    cur_sgn_q  <= cur_sgn_d;
    cur_size_q <= cur_size_d;
    off_q      <= off_d;
    mis_q      <= mis_d;
    lo_q       <= lo_d;
    hi_q       <= hi_d;
  end

  assign data_o    = data_o_q;
  assign valid     = valid_q;
  assign error     = error_q;
  assign dext_req  = dext_req_q;
  assign dext_wr   = dext_wr_q;
  assign dext_be   = dext_be_q;
  assign dext_addr = dext_addr_q;
  assign dext_do   = dext_do_q;

endmodule

// File: tb/tb_rv32_mod_lsu_queued.sv
// Directed bench for the queued LSU: a table of single requests with hand-computed
// bus beats and results, plus queue-fill, reset and misaligned-disabled sequences.
module tb_rv32_mod_lsu_queued;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, wr = 1'b0, dext_ack = 1'b0, dext_err = 1'b0;
  logic [3:0]  req_type = '0;
  logic [31:0] address = '0, data_i = '0, dext_di = '0;
  logic [31:0] data_o, dext_addr, dext_do;
  logic        valid, error, stall, dext_req, dext_wr;
  logic [3:0]  dext_be;

  logic        m_req = 1'b0, m_wr = 1'b0;
  logic [3:0]  m_req_type = '0;
  logic [31:0] m_address = '0, m_data_i = '0;
  logic [31:0] m_data_o, m_dext_addr, m_dext_do;
  logic        m_valid, m_error, m_stall, m_dext_req, m_dext_wr;
  logic [3:0]  m_dext_be;

  always #5 clk = ~clk;

  rv32_mod_lsu_queued #(.DEPTH(4), .MISALIGNED_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .req(req), .req_type(req_type), .wr(wr), .address(address),
    .data_i(data_i), .data_o(data_o), .valid(valid), .error(error), .stall(stall),
    .dext_req(dext_req), .dext_wr(dext_wr), .dext_ack(dext_ack), .dext_err(dext_err),
    .dext_be(dext_be), .dext_addr(dext_addr), .dext_do(dext_do), .dext_di(dext_di)
  );

  rv32_mod_lsu_queued #(.DEPTH(4), .MISALIGNED_EN(1'b0)) dut_noma (
    .clk(clk), .reset(reset), .req(m_req), .req_type(m_req_type), .wr(m_wr),
    .address(m_address), .data_i(m_data_i), .data_o(m_data_o), .valid(m_valid),
    .error(m_error), .stall(m_stall), .dext_req(m_dext_req), .dext_wr(m_dext_wr),
    .dext_ack(1'b0), .dext_err(1'b0), .dext_be(m_dext_be), .dext_addr(m_dext_addr),
    .dext_do(m_dext_do), .dext_di(32'h0)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  rtype;
    logic [31:0] addr, wdata, di0, di1;
    int          wt;
    logic        err0;
    int          nbeats;
    logic [31:0] addr0;
    logic [3:0]  be0;
    logic [31:0] do0;
    logic [3:0]  be1;
    logic [31:0] do1;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [12];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   t;
    logic busy;
    @(negedge clk);
    req = 1'b1; wr = v.wr; req_type = v.rtype; address = v.addr; data_i = v.wdata;
    @(negedge clk);
    req = 1'b0; wr = 1'b0; req_type = '0; address = '0; data_i = '0;
    busy = 1'b0;
    if (v.nbeats > 0) begin
      t = 0;
      while (!dext_req && t < 20) begin @(negedge clk); t++; end
      check("req_latency", t, 1);
      check("beat0_addr", dext_addr, v.addr0);
      check("beat0_be", {28'h0, dext_be}, {28'h0, v.be0});
      check("beat0_do", dext_do, v.do0);
      check("beat0_wr", {31'h0, dext_wr}, {31'h0, v.wr});
      repeat (v.wt) @(negedge clk);
      check("beat0_hold", {31'h0, dext_req}, 32'h1);
      dext_di = v.di0; dext_ack = !v.err0; dext_err = v.err0;
      @(negedge clk);
      dext_ack = 1'b0; dext_err = 1'b0; dext_di = '0;
      if (v.nbeats == 2) begin
        check("beat1_req", {31'h0, dext_req}, 32'h1);
        check("beat1_addr", dext_addr, v.addr0 + 32'd4);
        check("beat1_be", {28'h0, dext_be}, {28'h0, v.be1});
        check("beat1_do", dext_do, v.do1);
        dext_di = v.di1; dext_ack = 1'b1;
        @(negedge clk);
        dext_ack = 1'b0; dext_di = '0;
      end
      check("req_drop", {31'h0, dext_req}, 32'h0);
    end
    t = 0;
    while (!valid && !error && t < 20) begin
      if (dext_req) busy = 1'b1;
      @(negedge clk); t++;
    end
    check("resp_latency", t, (v.nbeats > 0) ? 1 : 2);
    check("bus_quiet", {31'h0, busy}, 32'h0);
    check("valid", {31'h0, valid}, {31'h0, !v.exp_err});
    check("error", {31'h0, error}, {31'h0, v.exp_err});
    check("data_o", data_o, v.exp_data);
    @(negedge clk);
    check("pulse_width", {30'h0, valid, error}, 32'h0);
  endtask

  initial begin
    int   k, nresp, stall_at, n_e, n_v;
    logic accept, busy;

    // wr rtype addr wdata di0 di1 wt err0 nbeats addr0 be0 do0 be1 do1 exp_err exp_data
    vecs[0]  = '{0, 4'b0010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 2, 0, 1,
                 32'h100, 4'b1111, 32'h0, 4'h0, 32'h0, 0, 32'hDEADBEEF};
    vecs[1]  = '{0, 4'b1000, 32'h103, 32'h0, 32'h80000000, 32'h0, 0, 0, 1,
                 32'h100, 4'b1000, 32'h0, 4'h0, 32'h0, 0, 32'hFFFFFF80};
    vecs[2]  = '{0, 4'b0000, 32'h103, 32'h0, 32'h80000000, 32'h0, 0, 0, 1,
                 32'h100, 4'b1000, 32'h0, 4'h0, 32'h0, 0, 32'h00000080};
    vecs[3]  = '{0, 4'b0010, 32'h102, 32'h0, 32'h22110000, 32'h00004433, 0, 0, 2,
                 32'h100, 4'b1100, 32'h0, 4'b0011, 32'h0, 0, 32'h44332211};
    vecs[4]  = '{1, 4'b0010, 32'h103, 32'h11223344, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 2,
                 32'h100, 4'b1000, 32'h44000000, 4'b0111, 32'h00112233, 0, 32'h0};
    vecs[5]  = '{0, 4'b1001, 32'h202, 32'h0, 32'h80010000, 32'h0, 1, 0, 1,
                 32'h200, 4'b1100, 32'h0, 4'h0, 32'h0, 0, 32'hFFFF8001};
    vecs[6]  = '{1, 4'b0001, 32'h201, 32'hABCD1234, 32'hFFFFFFFF, 32'h0, 0, 0, 1,
                 32'h200, 4'b0110, 32'h00123400, 4'h0, 32'h0, 0, 32'h0};
    vecs[7]  = '{0, 4'b0001, 32'h203, 32'h0, 32'hAA000000, 32'h000000BB, 0, 0, 2,
                 32'h200, 4'b1000, 32'h0, 4'b0001, 32'h0, 0, 32'h0000BBAA};
    vecs[8]  = '{0, 4'b0011, 32'h300, 32'h0, 32'h0, 32'h0, 0, 0, 0,
                 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, 1, 32'h0};
    vecs[9]  = '{1, 4'b0000, 32'h302, 32'hFFFFFF5A, 32'h0, 32'h0, 0, 0, 1,
                 32'h300, 4'b0100, 32'h005A0000, 4'h0, 32'h0, 0, 32'h0};
    vecs[10] = '{0, 4'b0010, 32'h106, 32'h0, 32'h12345678, 32'h0, 0, 1, 1,
                 32'h104, 4'b1100, 32'h0, 4'h0, 32'h0, 1, 32'h0};
    vecs[11] = '{0, 4'b1010, 32'h208, 32'h0, 32'h80000000, 32'h0, 0, 1, 1,
                 32'h208, 4'b1111, 32'h0, 4'h0, 32'h0, 1, 32'h0};

    repeat (2) @(negedge clk);
    check("rst_data_o", data_o, 32'h0);
    check("rst_addr", dext_addr, 32'h0);
    check("rst_do", dext_do, 32'h0);
    check("rst_ctrl", {23'h0, valid, error, stall, dext_req, dext_wr, dext_be}, 32'h0);
    check("rst_noma_ctrl", {23'h0, m_valid, m_error, m_stall, m_dext_req, m_dext_wr,
                            m_dext_be}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Queue fill against a stalled bus, then drain in order.
    @(negedge clk);
    k = 0; nresp = 0; stall_at = -1;
    req = 1'b1; wr = 1'b0; req_type = 4'b0010; address = 32'h400; data_i = '0;
    for (int c = 0; c < 100 && nresp < 6; c++) begin
      accept = req && !stall;
      if (stall && stall_at < 0) begin
        stall_at = k;
        check("full_bus_req", {31'h0, dext_req}, 32'h1);
        check("full_bus_addr", dext_addr, 32'h400);
      end
      dext_ack = (c >= 12) && dext_req;
      dext_di  = 32'h5000_0000 | dext_addr;
      @(negedge clk);
      if (valid) begin
        check("drain_order", data_o, 32'h5000_0400 + 32'(4 * nresp));
        nresp++;
      end
      if (accept) begin
        k++;
        if (k < 6) address = 32'h400 + 32'(4 * k);
        else req = 1'b0;
      end
    end
    dext_ack = 1'b0; dext_di = '0; req = 1'b0;
    check("stall_after", stall_at, 5);
    check("drain_count", nresp, 6);
    check("accepted", k, 6);

    // Reset while the second beat of a split load is outstanding.
    @(negedge clk);
    req = 1'b1; req_type = 4'b0010; address = 32'h502;
    @(negedge clk);
    req = 1'b0;
    for (int c = 0; c < 10 && !dext_req; c++) @(negedge clk);
    dext_ack = 1'b1; dext_di = 32'h11111111;
    @(negedge clk);
    dext_ack = 1'b0; dext_di = '0;
    check("rb_beat1_addr", dext_addr, 32'h504);
    check("rb_beat1_req", {31'h0, dext_req}, 32'h1);
    reset = 1'b1;
    #1;
    check("rb_ctrl", {23'h0, valid, error, stall, dext_req, dext_wr, dext_be}, 32'h0);
    check("rb_addr", dext_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    n_e = 0; busy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (valid || error) n_e++;
      if (dext_req) busy = 1'b1;
    end
    check("rb_no_pulse", n_e, 0);
    check("rb_bus_idle", {31'h0, busy}, 32'h0);
    run_vec(vecs[1]);

    // Misaligned access with splitting disabled.
    @(negedge clk);
    m_req = 1'b1; m_req_type = 4'b0010; m_address = 32'h102;
    @(negedge clk);
    m_req = 1'b0;
    n_e = 0; n_v = 0; busy = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_error) begin
        n_e++;
        check("noma_data", m_data_o, 32'h0);
      end
      if (m_valid) n_v++;
      if (m_dext_req) busy = 1'b1;
    end
    check("noma_errors", n_e, 1);
    check("noma_valids", n_v, 0);
    check("noma_bus_idle", {31'h0, busy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
